random_seq_gen: RTL and testbench

Pseudo-random LED-code sequence store for the Simon-style memory game, plus 7-segment decode of the two sequence indices. After reset it fills a 64-entry table of 2-bit codes from a seeded 16-bit LFSR. Two independent read ports return the code at any index, so the "show" side and the "replay/check" side see the same sequence. It sits between the game controller, which supplies indices, and the LED and display outputs. The display decode is built in the `digital_timer` sub-module.

---
 rtl/random_seq_gen_pkg.sv | 30 +++
 rtl/random_seq_gen_if.sv | 25 ++
 rtl/random_seq_gen_digital_timer.sv | 29 ++
 rtl/random_seq_gen.sv | 92 +++++++++
 tb/tb_random_seq_gen.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/random_seq_gen_pkg.sv
// Shared constants for the Simon sequence store: LFSR taps, seed fallback,
// table depth, "not ready" code and active-low 7-segment digit patterns.
package simon_pkg;

  localparam logic [15:0] LFSR_POLY      = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;
  localparam int          SEQ_DEPTH      = 64;
  localparam logic [2:0]  CODE_NONE      = 3'd4;

  // Segment patterns {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/random_seq_gen_if.sv
// Controller-facing bundle of the sequence store: seed/reseed and two read
// indices in, two codes, ready flag and two segment displays out.
interface random_seq_gen_if #(
  parameter int SEED_W = 16
);
  logic [SEED_W-1:0] seed;
  logic              reseed;
  logic [5:0]        idx_a;
  logic [5:0]        idx_b;
  logic [2:0]        code_a;
  logic [2:0]        code_b;
  logic              ready;
  logic [6:0]        seg_a;
  logic [6:0]        seg_b;

  modport master (
    output seed, reseed, idx_a, idx_b,
    input  code_a, code_b, ready, seg_a, seg_b
  );

  modport slave (
    input  seed, reseed, idx_a, idx_b,
    output code_a, code_b, ready, seg_a, seg_b
  );
endinterface

// File: rtl/random_seq_gen_digital_timer.sv
// Combinational units-digit decode of a 6-bit index onto an active-low
// 7-segment pattern; zero latency, no flow control.
module digital_timer
  import simon_pkg::*;
(
  input  logic [5:0] value,
  output logic [6:0] seg
);

  logic [3:0] digit;

  always_comb begin
    digit = 4'(value % 6'd10);
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/random_seq_gen.sv
// Simon sequence store: 64x2-bit table filled from a Galois LFSR in 64 cycles,
// two registered read ports (1-cycle latency) and registered index displays.
module random_seq_gen
  import simon_pkg::*;
#(
  parameter int SEED_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  random_seq_gen_if.slave     bus
);

  logic [0:0]  state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        load_q, load_d;
  logic [1:0]  tbl_q [SEQ_DEPTH];
  logic [1:0]  tbl_d [SEQ_DEPTH];
  logic [2:0]  code_a_q, code_a_d, code_b_q, code_b_d;
  logic [6:0]  seg_a_q, seg_a_d, seg_b_q, seg_b_d;

  logic [15:0] seed_ext;
  logic [15:0] start_val;
  logic [15:0] s_cur;

  assign seed_ext  = 16'(bus.seed);
  assign start_val = (seed_ext == 16'h0000) ? LFSR_ZERO_SEED : seed_ext;
  // The seed is taken on the first fill cycle, so reset never loads from a port.
  assign s_cur     = load_q ? start_val : lfsr_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    lfsr_d  = lfsr_q;
    load_d  = 1'b0;
    tbl_d   = tbl_q;
    if (bus.reseed) begin
      state_d = ST_FILL;
      i_d     = 6'd0;
      load_d  = 1'b1;
    end else if (state_q == ST_FILL) begin
      tbl_d[i_q] = s_cur[1:0];
      lfsr_d     = lfsr_next(s_cur);
      i_d        = i_q + 6'd1;
      if (i_q == 6'd63) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    code_a_d = (state_q == ST_RUN) ? {1'b0, tbl_q[bus.idx_a]} : CODE_NONE;
    code_b_d = (state_q == ST_RUN) ? {1'b0, tbl_q[bus.idx_b]} : CODE_NONE;
  end

  digital_timer u_disp_a (.value(bus.idx_a), .seg(seg_a_d));
  digital_timer u_disp_b (.value(bus.idx_b), .seg(seg_b_d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FILL;
      i_q      <= 6'd0;
      lfsr_q   <= LFSR_ZERO_SEED;
      load_q   <= 1'b1;
      code_a_q <= CODE_NONE;
      code_b_q <= CODE_NONE;
      seg_a_q  <= SEG_BLANK;
      seg_b_q  <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      lfsr_q   <= lfsr_d;
      load_q   <= load_d;
      code_a_q <= code_a_d;
      code_b_q <= code_b_d;
      seg_a_q  <= seg_a_d;
      seg_b_q  <= seg_b_d;
    end
  end

  // Table contents are meaningless until a fill completes, so no reset.
  always_ff @(posedge clk) begin
    tbl_q <= tbl_d;
  end

  assign bus.ready  = (state_q == ST_RUN);
  assign bus.code_a = code_a_q;
  assign bus.code_b = code_b_q;
  assign bus.seg_a  = seg_a_q;
  assign bus.seg_b  = seg_b_q;

endmodule

// File: tb/tb_random_seq_gen.sv
// Self-checking bench for random_seq_gen: fill timing, read ports, display
// decode, reseed and asynchronous reset, using an expected-value queue.
module tb_random_seq_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  random_seq_gen_if #(.SEED_W(16)) bus ();

  random_seq_gen #(.SEED_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [1:0] model_tbl [64];
  logic [2:0] q_ca [$];
  logic [2:0] q_cb [$];
  logic [6:0] q_sa [$];

  function automatic logic [6:0] seg_ref(input int v);
    case (v % 10)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  task automatic build_model(input logic [15:0] sd);
    logic [15:0] s;
    s = (sd == 16'h0000) ? 16'hACE1 : sd;
    for (int i = 0; i < 64; i++) begin
      model_tbl[i] = s[1:0];
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
  endtask

  task automatic test_reset();
    int  cyc;
    bit  early;
    bus.seed   = 16'h0000;
    bus.reseed = 1'b0;
    bus.idx_a  = 6'd0;
    bus.idx_b  = 6'd0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.code_a !== 3'd4) begin bad++; $display("FAIL reset_code_a got=%0d exp=4", bus.code_a); end
    total++; if (bus.code_b !== 3'd4) begin bad++; $display("FAIL reset_code_b got=%0d exp=4", bus.code_b); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    total++; if (bus.seg_a !== 7'h7F) begin bad++; $display("FAIL reset_seg_a got=%h exp=7f", bus.seg_a); end
    total++; if (bus.seg_b !== 7'h7F) begin bad++; $display("FAIL reset_seg_b got=%h exp=7f", bus.seg_b); end
    rst_n = 1'b1;
    cyc   = 0;
    early = 1'b0;
    while (bus.ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.ready !== 1'b1 && bus.code_a !== 3'd4) early = 1'b1;
    end
    total++; if (cyc != 64) begin bad++; $display("FAIL fill_cycles got=%0d exp=64", cyc); end
    total++; if (early) begin bad++; $display("FAIL fill_code_not_ready got=valid exp=4"); end
    total++; if (bus.code_a !== 3'd4) begin bad++; $display("FAIL code_on_ready_edge got=%0d exp=4", bus.code_a); end
  endtask

  task automatic test_seq_seed0();
    logic [2:0] exp_a [5];
    logic [2:0] ea, eb;
    exp_a = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd2};
    build_model(16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.idx_a = 6'(i);
      bus.idx_b = 6'(i + 5);
      q_ca.push_back(exp_a[i]);
      q_cb.push_back({1'b0, model_tbl[i + 5]});
      @(negedge clk);
      ea = q_ca.pop_front();
      eb = q_cb.pop_front();
      total++; if (bus.code_a !== ea) begin bad++; $display("FAIL seq0_a idx=%0d got=%0d exp=%0d", i, bus.code_a, ea); end
      total++; if (bus.code_b !== eb) begin bad++; $display("FAIL seq0_b idx=%0d got=%0d exp=%0d", i + 5, bus.code_b, eb); end
    end
  endtask

  task automatic test_dual_port();
    logic [5:0] ia [2];
    logic [5:0] ib [2];
    logic [2:0] ea, eb;
    ia = '{6'd3, 6'd0};
    ib = '{6'd3, 6'd4};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.idx_a = ia[k];
      bus.idx_b = ib[k];
      q_ca.push_back({1'b0, model_tbl[ia[k]]});
      q_cb.push_back({1'b0, model_tbl[ib[k]]});
      @(negedge clk);
      ea = q_ca.pop_front();
      eb = q_cb.pop_front();
      total++; if (bus.code_a !== ea) begin bad++; $display("FAIL dual_a k=%0d got=%0d exp=%0d", k, bus.code_a, ea); end
      total++; if (bus.code_b !== eb) begin bad++; $display("FAIL dual_b k=%0d got=%0d exp=%0d", k, bus.code_b, eb); end
    end
  endtask

  task automatic test_display();
    logic [5:0] ia [5];
    logic [6:0] es [5];
    logic [6:0] e;
    ia = '{6'd0, 6'd7, 6'd10, 6'd63, 6'd25};
    es = '{7'h40, 7'h78, 7'h40, 7'h30, 7'h12};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.idx_a = ia[k];
      bus.idx_b = 6'd59;
      q_sa.push_back(es[k]);
      @(negedge clk);
      e = q_sa.pop_front();
      total++; if (bus.seg_a !== e) begin bad++; $display("FAIL seg_a idx=%0d got=%h exp=%h", ia[k], bus.seg_a, e); end
      total++; if (bus.seg_b !== 7'h10) begin bad++; $display("FAIL seg_b idx=59 got=%h exp=10", bus.seg_b); end
    end
  endtask

  task automatic test_reseed();
    int cyc;
    logic [2:0] ea;
    bus.seed = 16'h0001;
    @(negedge clk);
    bus.reseed = 1'b1;
    @(negedge clk);
    bus.reseed = 1'b0;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reseed_ready_drop got=%b exp=0", bus.ready); end
    cyc = 0;
    while (bus.ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (cyc != 64) begin bad++; $display("FAIL reseed_fill_cycles got=%0d exp=64", cyc); end
    build_model(16'h0001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.idx_a = 6'(i);
      bus.idx_b = 6'(i);
      if (i == 0) q_ca.push_back(3'd1);
      else if (i == 1) q_ca.push_back(3'd0);
      else q_ca.push_back({1'b0, model_tbl[i]});
      @(negedge clk);
      ea = q_ca.pop_front();
      total++; if (bus.code_a !== ea) begin bad++; $display("FAIL reseed_code idx=%0d got=%0d exp=%0d", i, bus.code_a, ea); end
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    logic [2:0] ea;
    bus.seed  = 16'h0000;
    bus.idx_a = 6'd7;
    @(negedge clk);
    bus.reseed = 1'b1;
    @(negedge clk);
    bus.reseed = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b exp=0", bus.ready); end
    total++; if (bus.code_a !== 3'd4) begin bad++; $display("FAIL arst_code_a got=%0d exp=4", bus.code_a); end
    total++; if (bus.seg_a !== 7'h7F) begin bad++; $display("FAIL arst_seg_a got=%h exp=7f", bus.seg_a); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (bus.ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (cyc != 64) begin bad++; $display("FAIL arst_fill_cycles got=%0d exp=64", cyc); end
    build_model(16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.idx_a = 6'(i);
      q_ca.push_back({1'b0, model_tbl[i]});
      @(negedge clk);
      ea = q_ca.pop_front();
      total++; if (bus.code_a !== ea) begin bad++; $display("FAIL arst_seq idx=%0d got=%0d exp=%0d", i, bus.code_a, ea); end
    end
  endtask

  task automatic test_sweep();
    int hist [4];
    logic [2:0] ea, eb;
    hist = '{0, 0, 0, 0};
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bus.idx_a = 6'(i);
      bus.idx_b = 6'(63 - i);
      q_ca.push_back({1'b0, model_tbl[i]});
      q_cb.push_back({1'b0, model_tbl[63 - i]});
      @(negedge clk);
      ea = q_ca.pop_front();
      eb = q_cb.pop_front();
      total++; if (bus.code_a !== ea) begin bad++; $display("FAIL sweep_a idx=%0d got=%0d exp=%0d", i, bus.code_a, ea); end
      total++; if (bus.code_b !== eb) begin bad++; $display("FAIL sweep_b idx=%0d got=%0d exp=%0d", 63 - i, bus.code_b, eb); end
      if (bus.code_a <= 3'd3) hist[bus.code_a[1:0]]++;
    end
    for (int v = 0; v < 4; v++) begin
      total++; if (hist[v] == 0) begin bad++; $display("FAIL sweep_value_present value=%0d got=0 exp>=1", v); end
    end
  endtask

  initial begin
    test_reset();
    test_seq_seed0();
    test_dual_port();
    test_display();
    test_reseed();
    test_async_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
